// File: rtl/p4_router_pkg.sv
// p4_router_pkg: shared types and constants for the P4 router ingress path.
// Holds the arbiter FSM encoding, the width-class table used to size
// DATA_BYTES for each arbiter instance, and a helper for index widths.
package p4_router_pkg;

    localparam int MAX_ARB_PORTS = 16;

    typedef enum logic {
        ARB_IDLE,
        ARB_LOCKED
    } arb_state_t;

    // One arbiter instance per ingress width class.
    typedef enum logic [1:0] {
        WIDTH_IDX_8B,
        WIDTH_IDX_16B,
        WIDTH_IDX_32B,
        WIDTH_IDX_64B
    } width_index_t;

    // DATA_BYTES for each width class, indexed by width_index_t.
    localparam int WIDTH_INDEX_BYTES [4] = '{1, 2, 4, 8};

    // Width of a port index; a single-port arbiter still needs one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/p4_router_rr_pick.sv
// p4_router_rr_pick: combinational round-robin pick. Searches the request
// vector starting one past last_grant and wrapping at NUM_PORTS-1 -> 0.
module p4_router_rr_pick
    import p4_router_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int IDX_W     = idx_width(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [IDX_W-1:0]     last_grant,
    output logic                 hit,
    output logic [IDX_W-1:0]     grant
);

    int               cand;
    logic [IDX_W-1:0] cand_idx;

    // Walk offsets from farthest to nearest so the nearest requester wins.
    always_comb begin
        hit      = 1'b0;
        grant    = '0;
        cand     = 0;
        cand_idx = '0;
        for (int i = NUM_PORTS; i >= 1; i--) begin
            cand     = (int'(last_grant) + i) % NUM_PORTS;
            cand_idx = IDX_W'(cand);
            if (req[cand_idx]) begin
                hit   = 1'b1;
                grant = cand_idx;
            end
        end
    end

endmodule

// File: rtl/p4_router_port_arbiter.sv
// p4_router_port_arbiter: packet-atomic round-robin AXI-Stream merge of
// NUM_PORTS ingress ports into one registered output stream, each beat
// tagged with PORT_ID_OFFSET + local port index.
// Optional per-port completed-packet counters: define P4_ROUTER_ARB_STATS_EN.
module p4_router_port_arbiter
    import p4_router_pkg::*;
#(
    parameter int NUM_PORTS      = 4,
    parameter int DATA_BYTES     = 8,
    parameter int TID_WIDTH      = 8,
    parameter int PORT_ID_OFFSET = 0
) (
    input  logic                             clk,
    input  logic                             areset,
    input  logic [NUM_PORTS*DATA_BYTES*8-1:0] s_tdata,
    input  logic [NUM_PORTS*DATA_BYTES-1:0]   s_tkeep,
    input  logic [NUM_PORTS-1:0]              s_tvalid,
    input  logic [NUM_PORTS-1:0]              s_tlast,
    output logic [NUM_PORTS-1:0]              s_tready,
    output logic [DATA_BYTES*8-1:0]           m_tdata,
    output logic [DATA_BYTES-1:0]             m_tkeep,
    output logic                              m_tvalid,
    output logic                              m_tlast,
    output logic [TID_WIDTH-1:0]              m_tid,
    input  logic                              m_tready,
    output logic [NUM_PORTS*32-1:0]           pkt_count
);

    localparam int     IDX_W   = idx_width(NUM_PORTS);
    localparam int     DW      = DATA_BYTES * 8;
    localparam longint MAX_TID = longint'(PORT_ID_OFFSET) + longint'(NUM_PORTS) - 1;

    if (NUM_PORTS < 1 || NUM_PORTS > MAX_ARB_PORTS) begin : g_chk_ports
        $error("p4_router_port_arbiter: NUM_PORTS must be 1..%0d", MAX_ARB_PORTS);
    end
    if (!(DATA_BYTES == 1 || DATA_BYTES == 2 || DATA_BYTES == 4 || DATA_BYTES == 8)) begin : g_chk_bytes
        $error("p4_router_port_arbiter: DATA_BYTES must be 1, 2, 4 or 8");
    end
    if (TID_WIDTH < 63 && (MAX_TID >> TID_WIDTH) != 0) begin : g_chk_tid
        $error("p4_router_port_arbiter: PORT_ID_OFFSET+NUM_PORTS-1 does not fit in TID_WIDTH");
    end

    arb_state_t        state_q;
    logic [IDX_W-1:0]  grant_q;
    logic [IDX_W-1:0]  last_grant_q;
    logic [DW-1:0]     m_tdata_q;
    logic [DATA_BYTES-1:0] m_tkeep_q;
    logic              m_tvalid_q;
    logic              m_tlast_q;
    logic [TID_WIDTH-1:0] m_tid_q;

    logic              pick_hit;
    logic [IDX_W-1:0]  pick_grant;
    logic              out_ready;
    logic              beat_accept;
    logic              sel_last;
    logic [DW-1:0]         port_data [NUM_PORTS];
    logic [DATA_BYTES-1:0] port_keep [NUM_PORTS];

    p4_router_rr_pick #(
        .NUM_PORTS (NUM_PORTS),
        .IDX_W     (IDX_W)
    ) u_pick (
        .req        (s_tvalid),
        .last_grant (last_grant_q),
        .hit        (pick_hit),
        .grant      (pick_grant)
    );

    // The output register can take a new beat when empty or being drained.
    assign out_ready = !m_tvalid_q || m_tready;

    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
        assign port_data[gi] = s_tdata[gi*DW +: DW];
        assign port_keep[gi] = s_tkeep[gi*DATA_BYTES +: DATA_BYTES];
        assign s_tready[gi]  = (state_q == ARB_LOCKED) && (grant_q == IDX_W'(gi)) && out_ready;
    end

    assign beat_accept = |(s_tvalid & s_tready);
    assign sel_last    = s_tlast[grant_q];

    // Arbitration FSM: pick in IDLE, hold the grant until the tlast beat is taken.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_q      <= ARB_IDLE;
            grant_q      <= '0;
            last_grant_q <= IDX_W'(NUM_PORTS - 1);
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    if (pick_hit) begin
                        grant_q      <= pick_grant;
                        last_grant_q <= pick_grant;
                        state_q      <= ARB_LOCKED;
                    end
                end
                ARB_LOCKED: begin
                    if (beat_accept && sel_last) begin
                        state_q <= ARB_IDLE;
                    end
                end
                default: state_q <= ARB_IDLE;
            endcase
        end
    end

    // Output register slice: loads on each accepted beat, holds under backpressure.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            m_tvalid_q <= 1'b0;
            m_tlast_q  <= 1'b0;
            m_tdata_q  <= '0;
            m_tkeep_q  <= '0;
            m_tid_q    <= '0;
        end else if (out_ready) begin
            m_tvalid_q <= beat_accept;
            if (beat_accept) begin
                m_tdata_q <= port_data[grant_q];
                m_tkeep_q <= port_keep[grant_q];
                m_tlast_q <= sel_last;
                m_tid_q   <= TID_WIDTH'(32'(PORT_ID_OFFSET) + 32'(grant_q));
            end
        end
    end

    assign m_tvalid = m_tvalid_q;
    assign m_tlast  = m_tlast_q;
    assign m_tdata  = m_tdata_q;
    assign m_tkeep  = m_tkeep_q;
    assign m_tid    = m_tid_q;

`ifdef P4_ROUTER_ARB_STATS_EN
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_stats
        logic [31:0] cnt_q;

        // Count packets whose tlast beat was accepted from this port; wraps at 2^32.
        always_ff @(posedge clk or posedge areset) begin
            if (areset) begin
                cnt_q <= '0;
            end else if (s_tvalid[gi] && s_tready[gi] && s_tlast[gi]) begin
                cnt_q <= cnt_q + 32'd1;
            end
        end

        assign pkt_count[gi*32 +: 32] = cnt_q;
    end
`else
    assign pkt_count = '0;
`endif

endmodule

// File: tb/tb_p4_router_port_arbiter.sv
// Testbench for p4_router_port_arbiter: per-port source queues feed the DUT,
// tests push hand-ordered expected beats into a scoreboard, and a monitor
// pops and compares on every output handshake.
`timescale 1ns/1ps
module tb_p4_router_port_arbiter;

    localparam int NP   = 4;
    localparam int DB   = 8;
    localparam int DW   = DB * 8;
    localparam int TW   = 8;
    localparam int OFFS = 8;

    logic                clk    = 1'b0;
    logic                areset = 1'b1;
    logic [NP*DW-1:0]    s_tdata  = '0;
    logic [NP*DB-1:0]    s_tkeep  = '0;
    logic [NP-1:0]       s_tvalid = '0;
    logic [NP-1:0]       s_tlast  = '0;
    logic [NP-1:0]       s_tready;
    logic [DW-1:0]       m_tdata;
    logic [DB-1:0]       m_tkeep;
    logic                m_tvalid;
    logic                m_tlast;
    logic [TW-1:0]       m_tid;
    logic                m_tready = 1'b1;
    logic [NP*32-1:0]    pkt_count;

    p4_router_port_arbiter #(
        .NUM_PORTS      (NP),
        .DATA_BYTES     (DB),
        .TID_WIDTH      (TW),
        .PORT_ID_OFFSET (OFFS)
    ) dut (
        .clk       (clk),
        .areset    (areset),
        .s_tdata   (s_tdata),
        .s_tkeep   (s_tkeep),
        .s_tvalid  (s_tvalid),
        .s_tlast   (s_tlast),
        .s_tready  (s_tready),
        .m_tdata   (m_tdata),
        .m_tkeep   (m_tkeep),
        .m_tvalid  (m_tvalid),
        .m_tlast   (m_tlast),
        .m_tid     (m_tid),
        .m_tready  (m_tready),
        .pkt_count (pkt_count)
    );

    typedef struct {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
        int          gap;
    } src_beat_t;

    typedef struct {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
        logic [7:0]  tid;
        int          cyc;
    } exp_beat_t;

    src_beat_t src_q [NP][$];
    exp_beat_t exp_q [$];
    int        gap_left [NP];
    bit        loaded [NP];
    bit        hs [NP];
    int        cyc    = 0;
    int        checks = 0;
    int        errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] mk_data(input int p, input int pkt, input int b);
        return {8'(p), 8'(pkt), 16'(b), 32'hC0DE_0000 + 32'(p * 256 + pkt * 16 + b)};
    endfunction

    function automatic logic [7:0] mk_keep(input int pkt, input int b, input int nb);
        logic [7:0] full;
        full = 8'hFF;
        return (b == nb - 1) ? (full >> (pkt % 8)) : full;
    endfunction

    task automatic push_src(input int p, input int pkt, input int b, input int nb, input int gap);
        src_beat_t s;
        s.data = mk_data(p, pkt, b);
        s.keep = mk_keep(pkt, b, nb);
        s.last = (b == nb - 1);
        s.gap  = gap;
        src_q[p].push_back(s);
    endtask

    task automatic add_pkt(input int p, input int pkt, input int nb, input int gap0);
        for (int b = 0; b < nb; b++) push_src(p, pkt, b, nb, (b == 0) ? gap0 : 0);
    endtask

    task automatic exp_beat(input int p, input int pkt, input int b, input int nb, input int c);
        exp_beat_t e;
        e.data = mk_data(p, pkt, b);
        e.keep = mk_keep(pkt, b, nb);
        e.last = (b == nb - 1);
        e.tid  = 8'(OFFS + p);
        e.cyc  = c;
        exp_q.push_back(e);
    endtask

    task automatic exp_pkt(input int p, input int pkt, input int nb, input int c0);
        for (int b = 0; b < nb; b++) exp_beat(p, pkt, b, nb, (c0 < 0) ? -1 : c0 + b);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic flush_src();
        for (int p = 0; p < NP; p++) begin
            src_q[p].delete();
            loaded[p]   = 1'b0;
            hs[p]       = 1'b0;
            gap_left[p] = 0;
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_m_tvalid"}, 64'(m_tvalid), 64'd0);
        chk({tag, "_m_tlast"},  64'(m_tlast),  64'd0);
        chk({tag, "_m_tdata"},  m_tdata,       64'd0);
        chk({tag, "_m_tkeep"},  64'(m_tkeep),  64'd0);
        chk({tag, "_m_tid"},    64'(m_tid),    64'd0);
        chk({tag, "_s_tready"}, 64'(s_tready), 64'd0);
        chk({tag, "_pkt_count"}, pkt_count[63:0] | pkt_count[127:64], 64'd0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        areset = 1'b1;
        @(negedge clk);
        flush_src();
        check_reset("rst");
        @(posedge clk); #1;
        areset = 1'b0;
    endtask

    // Returns the cycle in which beats queued now are first presented.
    task automatic begin_at(output int t0);
        @(negedge clk);
        t0 = cyc + 1;
    endtask

    // Lands just after the active edge that starts cycle n.
    task automatic goto_cycle(input int n);
        @(posedge clk); #1;
        while (cyc < n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            @(negedge clk);
            done = (exp_q.size() == 0);
            for (int p = 0; p < NP; p++) if (src_q[p].size() != 0) done = 1'b0;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL drain_timeout: got %0d beats outstanding expected 0", exp_q.size());
        end
        repeat (3) @(negedge clk);
    endtask

    // Source driver: one beat per port, honouring inter-beat gaps.
    initial begin
        forever begin
            @(posedge clk); #1;
            for (int p = 0; p < NP; p++) begin
                if (hs[p] && src_q[p].size() > 0) begin
                    void'(src_q[p].pop_front());
                    loaded[p] = 1'b0;
                end
                hs[p] = 1'b0;
                if (!loaded[p] && src_q[p].size() > 0) begin
                    gap_left[p] = src_q[p][0].gap;
                    loaded[p]   = 1'b1;
                end
                if (loaded[p] && gap_left[p] == 0) begin
                    s_tvalid[p]          = 1'b1;
                    s_tdata[p*DW +: DW]  = src_q[p][0].data;
                    s_tkeep[p*DB +: DB]  = src_q[p][0].keep;
                    s_tlast[p]           = src_q[p][0].last;
                end else begin
                    s_tvalid[p] = 1'b0;
                    s_tlast[p]  = 1'b0;
                    if (loaded[p]) gap_left[p]--;
                end
            end
        end
    end

    // Monitor: records ingress handshakes and checks every output handshake.
    initial begin
        exp_beat_t e;
        forever begin
            @(negedge clk);
            for (int p = 0; p < NP; p++) hs[p] = s_tvalid[p] && s_tready[p];
            if (m_tvalid && m_tready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL beat_unexpected: got data=%h tid=%0d cyc=%0d expected no beat",
                             m_tdata, m_tid, cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (m_tdata !== e.data || m_tkeep !== e.keep || m_tlast !== e.last ||
                        m_tid !== e.tid || (e.cyc >= 0 && cyc != e.cyc)) begin
                        errors++;
                        $display("FAIL beat: got data=%h keep=%h last=%b tid=%0d cyc=%0d expected data=%h keep=%h last=%b tid=%0d cyc=%0d",
                                 m_tdata, m_tkeep, m_tlast, m_tid, cyc,
                                 e.data, e.keep, e.last, e.tid, e.cyc);
                    end else begin
                        $display("beat data=%h keep=%h last=%b tid=%0d cyc=%0d",
                                 m_tdata, m_tkeep, m_tlast, m_tid, cyc);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: got no finish expected finish before 200000ns");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t0;

        // Two 3-beat packets on ports 0 and 2 straight out of reset.
        do_reset();
        begin_at(t0);
        add_pkt(0, 1, 3, 0);
        add_pkt(2, 1, 3, 0);
        exp_pkt(0, 1, 3, t0 + 2);
        exp_pkt(2, 1, 3, t0 + 6);
        wait_idle();

        // All ports, single-beat packets: RR order 0,1,2,3 with a bubble each time.
        do_reset();
        begin_at(t0);
        for (int k = 0; k < 3; k++)
            for (int p = 0; p < NP; p++) add_pkt(p, 10 + k, 1, 0);
        for (int k = 0; k < 3; k++)
            for (int p = 0; p < NP; p++) exp_pkt(p, 10 + k, 1, t0 + 2 + 2 * (4 * k + p));
        wait_idle();

        // Backpressure: m_tready low for 5 cycles while beat 2 of port 1 is on the output.
        begin_at(t0);
        add_pkt(1, 20, 6, 0);
        exp_beat(1, 20, 0, 6, t0 + 2);
        exp_beat(1, 20, 1, 6, t0 + 3);
        exp_beat(1, 20, 2, 6, t0 + 9);
        for (int b = 3; b < 6; b++) exp_beat(1, 20, b, 6, t0 + 7 + b);
        goto_cycle(t0 + 4);
        m_tready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_m_tvalid", 64'(m_tvalid), 64'd1);
            chk("hold_m_tdata",  m_tdata,       mk_data(1, 20, 2));
            chk("hold_m_tid",    64'(m_tid),    64'(OFFS + 1));
            chk("hold_s_tready", 64'(s_tready), 64'd0);
        end
        @(posedge clk); #1;
        m_tready = 1'b1;
        wait_idle();

        // Port 1 stalls mid-packet; port 3 must wait for port 1's tlast.
        begin_at(t0);
        push_src(1, 30, 0, 4, 0);
        push_src(1, 30, 1, 4, 0);
        push_src(1, 30, 2, 4, 4);
        push_src(1, 30, 3, 4, 0);
        add_pkt(3, 31, 2, 1);
        exp_beat(1, 30, 0, 4, t0 + 2);
        exp_beat(1, 30, 1, 4, t0 + 3);
        exp_beat(1, 30, 2, 4, t0 + 8);
        exp_beat(1, 30, 3, 4, t0 + 9);
        exp_pkt(3, 31, 2, t0 + 11);
        goto_cycle(t0 + 5);
        @(negedge clk);
        chk("lock_s_tready", 64'(s_tready), 64'h2);
        wait_idle();

        // Reset on the 2nd beat of a 4-beat packet; port 0 wins afterwards.
        begin_at(t0);
        add_pkt(2, 40, 4, 0);
        exp_beat(2, 40, 0, 4, t0 + 2);
        goto_cycle(t0 + 3);
        areset = 1'b1;
        @(negedge clk);
        check_reset("midpkt");
        flush_src();
        add_pkt(0, 41, 1, 0);
        add_pkt(1, 42, 1, 0);
        add_pkt(3, 43, 1, 0);
        exp_pkt(0, 41, 1, t0 + 7);
        exp_pkt(1, 42, 1, t0 + 9);
        exp_pkt(3, 43, 1, t0 + 11);
        goto_cycle(t0 + 5);
        areset = 1'b0;
        wait_idle();

        // Packet counters: 5 packets on port 3, 2 on port 0.
        do_reset();
        begin_at(t0);
        for (int k = 0; k < 5; k++) add_pkt(3, 50 + k, 2, 0);
        for (int k = 0; k < 2; k++) add_pkt(0, 60 + k, 1, 0);
        exp_pkt(0, 60, 1, -1);
        exp_pkt(3, 50, 2, -1);
        exp_pkt(0, 61, 1, -1);
        for (int k = 1; k < 5; k++) exp_pkt(3, 50 + k, 2, -1);
        wait_idle();
`ifdef P4_ROUTER_ARB_STATS_EN
        chk("pkt_count0", 64'(pkt_count[31:0]),   64'd2);
        chk("pkt_count1", 64'(pkt_count[63:32]),  64'd0);
        chk("pkt_count2", 64'(pkt_count[95:64]),  64'd0);
        chk("pkt_count3", 64'(pkt_count[127:96]), 64'd5);
`else
        chk("pkt_count0", 64'(pkt_count[31:0]),   64'd0);
        chk("pkt_count1", 64'(pkt_count[63:32]),  64'd0);
        chk("pkt_count2", 64'(pkt_count[95:64]),  64'd0);
        chk("pkt_count3", 64'(pkt_count[127:96]), 64'd0);
`endif
        chk("end_m_tvalid", 64'(m_tvalid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
